// File: rtl/hart_arb_pkg.sv
// Shared definitions for the hart memory-port arbiter: FSM state encoding,
// payload field widths and the modulo helper used by the round-robin picker.
package hart_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 3;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_ISSUE  = 3'd1,
    ARB_WAIT   = 3'd2,
    ARB_DONE   = 3'd3,
    ARB_LOCKED = 3'd4
  } arb_state_t;

  // Hart index that lies 'step' positions after 'base' on a ring of n harts.
  function automatic int rr_wrap(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the requester closest after the last
// owner (wrapping around) wins, so the last owner has lowest priority.
module rr_pick
  import hart_arb_pkg::*;
#(
  parameter int N_HARTS = 2
) (
  input  logic [N_HARTS-1:0]         i_req,
  input  logic [$clog2(N_HARTS)-1:0] i_last,
  output logic [$clog2(N_HARTS)-1:0] o_idx,
  output logic                       o_vld
);

  localparam int IDX_W = $clog2(N_HARTS);

  logic [IDX_W-1:0] w_cand;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    o_idx  = '0;
    o_vld  = 1'b0;
    w_cand = '0;
    for (int i = N_HARTS; i >= 1; i--) begin
      w_cand = IDX_W'(rr_wrap(int'(i_last), i, N_HARTS));
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Shares one memory/MMU access port between N_HARTS hart ports. Each access
// runs issue -> wait -> complete; an owner may hold the port across accesses
// with i_lock, bounded by an idle watchdog of LOCK_MAX cycles.
module hart_mem_arbiter
  import hart_arb_pkg::*;
#(
  parameter int N_HARTS  = 2,
  parameter int LOCK_MAX = 64,
  parameter int IDX_W    = $clog2(N_HARTS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_HARTS-1:0]        i_req,
  input  logic [ADDR_W*N_HARTS-1:0] i_addr,
  input  logic [DATA_W*N_HARTS-1:0] i_wdata,
  input  logic [N_HARTS-1:0]        i_we,
  input  logic [CTRL_W*N_HARTS-1:0] i_ctrl,
  input  logic [N_HARTS-1:0]        i_lock,
  output logic [N_HARTS-1:0]        o_gnt,
  output logic [N_HARTS-1:0]        o_done,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_mem_req,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  output logic                      o_mem_we,
  output logic [CTRL_W-1:0]         o_mem_ctrl,
  input  logic                      i_mem_busy,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  output logic [IDX_W-1:0]          o_owner,
  output logic                      o_idle
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [N_HARTS-1:0] ONE_HOT0 = {{(N_HARTS-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(N_HARTS - 1);

  arb_state_t          r_state;
  logic                r_idle;
  logic [N_HARTS-1:0]  r_gnt;
  logic [N_HARTS-1:0]  r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_we;
  logic [CTRL_W-1:0]   r_mem_ctrl;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_last;
  logic [CNT_W-1:0]    r_lock_cnt;

  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_vld;
  logic [IDX_W-1:0]    w_sel;
  logic [ADDR_W-1:0]   w_addr_a  [N_HARTS];
  logic [DATA_W-1:0]   w_wdata_a [N_HARTS];
  logic [CTRL_W-1:0]   w_ctrl_a  [N_HARTS];

  // Split the flat per-hart payload buses into indexable arrays.
  for (genvar g = 0; g < N_HARTS; g++) begin : g_unpack
    assign w_addr_a[g]  = i_addr[ADDR_W*g +: ADDR_W];
    assign w_wdata_a[g] = i_wdata[DATA_W*g +: DATA_W];
    assign w_ctrl_a[g]  = i_ctrl[CTRL_W*g +: CTRL_W];
  end

  rr_pick #(
    .N_HARTS (N_HARTS)
  ) u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_idx  (w_pick_idx),
    .o_vld  (w_pick_vld)
  );

  // In IDLE the payload comes from the new winner; in LOCKED from the owner.
  assign w_sel = (r_state == ARB_IDLE) ? w_pick_idx : r_owner;

  // Arbitration FSM with registered grant, strobes, payload and lock watchdog.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ARB_IDLE;
      r_idle      <= 1'b1;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_ctrl  <= '0;
      r_owner     <= '0;
      r_last      <= LAST_RST;
      r_lock_cnt  <= '0;
    end else begin
      r_done    <= '0;
      r_mem_req <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_vld) begin
            r_owner     <= w_pick_idx;
            r_gnt       <= ONE_HOT0 << w_pick_idx;
            r_mem_addr  <= w_addr_a[w_sel];
            r_mem_wdata <= w_wdata_a[w_sel];
            r_mem_we    <= i_we[w_sel];
            r_mem_ctrl  <= w_ctrl_a[w_sel];
            r_mem_req   <= 1'b1;
            r_idle      <= 1'b0;
            r_state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          r_state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (!i_mem_busy) begin
            r_rdata <= i_mem_rdata;
            r_done  <= ONE_HOT0 << r_owner;
            r_state <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          r_last <= r_owner;
          if (i_lock[r_owner]) begin
            r_lock_cnt <= '0;
            r_state    <= ARB_LOCKED;
          end else begin
            r_gnt   <= '0;
            r_idle  <= 1'b1;
            r_state <= ARB_IDLE;
          end
        end
        ARB_LOCKED: begin
          // A fresh request from the owner beats any release condition.
          if (i_req[r_owner]) begin
            r_mem_addr  <= w_addr_a[w_sel];
            r_mem_wdata <= w_wdata_a[w_sel];
            r_mem_we    <= i_we[w_sel];
            r_mem_ctrl  <= w_ctrl_a[w_sel];
            r_mem_req   <= 1'b1;
            r_state     <= ARB_ISSUE;
          end else if (!i_lock[r_owner] || (r_lock_cnt == CNT_LAST)) begin
            r_gnt   <= '0;
            r_idle  <= 1'b1;
            r_state <= ARB_IDLE;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_idle  <= 1'b1;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_mem_ctrl  = r_mem_ctrl;
  assign o_owner     = r_owner;
  assign o_idle      = r_idle;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Self-checking bench for hart_mem_arbiter: directed scenarios plus a random
// request phase, checked against a transaction-level round-robin model.
module tb_hart_mem_arbiter;

  localparam int NH = 2;
  localparam int LM = 16;
  localparam int IW = $clog2(NH);

  typedef logic [IW-1:0] hid_t;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NH-1:0]     i_req;
  wire  [32*NH-1:0]  i_addr;
  wire  [32*NH-1:0]  i_wdata;
  wire  [NH-1:0]     i_we;
  wire  [3*NH-1:0]   i_ctrl;
  logic [NH-1:0]     i_lock;
  logic [NH-1:0]     o_gnt;
  logic [NH-1:0]     o_done;
  logic [31:0]       o_rdata;
  logic              o_mem_req;
  logic [31:0]       o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              o_mem_we;
  logic [2:0]        o_mem_ctrl;
  logic              i_mem_busy;
  logic [31:0]       i_mem_rdata;
  hid_t              o_owner;
  logic              o_idle;

  logic [31:0] pa_addr  [NH];
  logic [31:0] pa_wdata [NH];
  logic        pa_we    [NH];
  logic [2:0]  pa_ctrl  [NH];

  int   total = 0;
  int   bad   = 0;
  hid_t m_last;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NH; g++) begin : g_pack
    assign i_addr[32*g +: 32] = pa_addr[g];
    assign i_wdata[32*g +: 32] = pa_wdata[g];
    assign i_we[g]             = pa_we[g];
    assign i_ctrl[3*g +: 3]    = pa_ctrl[g];
  end

  hart_mem_arbiter #(
    .N_HARTS  (NH),
    .LOCK_MAX (LM)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_we        (i_we),
    .i_ctrl      (i_ctrl),
    .i_lock      (i_lock),
    .o_gnt       (o_gnt),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_we    (o_mem_we),
    .o_mem_ctrl  (o_mem_ctrl),
    .i_mem_busy  (i_mem_busy),
    .i_mem_rdata (i_mem_rdata),
    .o_owner     (o_owner),
    .o_idle      (o_idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_payload(input hid_t k);
    pa_addr[k]  = $urandom;
    pa_wdata[k] = $urandom;
    pa_we[k]    = 1'($urandom_range(0, 1));
    pa_ctrl[k]  = 3'($urandom_range(0, 7));
  endtask

  // Next owner: first requester at ring distance 1..NH from the last owner.
  function automatic hid_t rr_model(input logic [NH-1:0] m, input hid_t last);
    hid_t r;
    bit   found;
    int   c;
    r     = last;
    found = 1'b0;
    for (int d = 1; d <= NH; d++) begin
      c = (int'(last) + d) % NH;
      if (!found && m[hid_t'(c)]) begin
        r     = hid_t'(c);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk_reset_vals(input string ph);
    chk({ph, "_gnt"},   32'(o_gnt), 32'd0);
    chk({ph, "_done"},  32'(o_done), 32'd0);
    chk({ph, "_rdata"}, o_rdata, 32'd0);
    chk({ph, "_mreq"},  32'(o_mem_req), 32'd0);
    chk({ph, "_maddr"}, o_mem_addr, 32'd0);
    chk({ph, "_mwdat"}, o_mem_wdata, 32'd0);
    chk({ph, "_mwe"},   32'(o_mem_we), 32'd0);
    chk({ph, "_mctrl"}, 32'(o_mem_ctrl), 32'd0);
    chk({ph, "_owner"}, 32'(o_owner), 32'd0);
    chk({ph, "_idle"},  32'(o_idle), 32'd1);
  endtask

  // Acts as the shared port for one access by 'own': waits for the issue
  // strobe, keeps busy high for 'lat' WAIT cycles, then returns 'rd'.
  // exp_mreq < 0 skips the issue-latency check. Returns in the DONE cycle.
  task automatic serve(input hid_t own, input int lat, input logic [31:0] rd,
                       input bit drop, input int exp_mreq);
    int cyc, mcyc, rem;
    bit seen, fin;
    cyc = 0; mcyc = 0; rem = 0; seen = 1'b0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      tick();
      cyc++;
      if (!seen) begin
        if (o_mem_req) begin
          seen = 1'b1;
          mcyc = cyc;
          if (exp_mreq >= 0) chk("issue_latency", cyc, exp_mreq);
          chk("issue_gnt",   32'(o_gnt), 32'(1) << own);
          chk("issue_owner", 32'(o_owner), 32'(own));
          chk("issue_addr",  o_mem_addr, pa_addr[own]);
          chk("issue_wdata", o_mem_wdata, pa_wdata[own]);
          chk("issue_we",    32'(o_mem_we), 32'(pa_we[own]));
          chk("issue_ctrl",  32'(o_mem_ctrl), 32'(pa_ctrl[own]));
          rem         = lat + 1;
          i_mem_busy  = (lat > 0);
          i_mem_rdata = (lat == 0) ? rd : $urandom;
        end
      end else if (o_done != '0) begin
        chk("done_vec",   32'(o_done), 32'(1) << own);
        chk("done_lat",   cyc, mcyc + 2 + lat);
        chk("done_rdata", o_rdata, rd);
        chk("hold_addr",  o_mem_addr, pa_addr[own]);
        chk("hold_wdata", o_mem_wdata, pa_wdata[own]);
        chk("hold_ctrl",  32'(o_mem_ctrl), 32'(pa_ctrl[own]));
        if (drop) i_req[own] = 1'b0;
        m_last = own;
        fin    = 1'b1;
      end else begin
        chk("mreq_pulse", 32'(o_mem_req), 32'd0);
        rem--;
        i_mem_busy  = (rem > 0);
        i_mem_rdata = (rem <= 0) ? rd : $urandom;
      end
    end
    chk("serve_timeout", 32'(fin), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [NH-1:0] pend;
    logic [NH-1:0] nb;
    hid_t          own;
    logic [31:0]   rd;

    RST         = 1'b1;
    i_req       = '0;
    i_lock      = '0;
    i_mem_busy  = 1'b0;
    i_mem_rdata = '0;
    m_last      = hid_t'(NH - 1);
    for (int k = 0; k < NH; k++) begin
      pa_addr[hid_t'(k)]  = '0;
      pa_wdata[hid_t'(k)] = '0;
      pa_we[hid_t'(k)]    = 1'b0;
      pa_ctrl[hid_t'(k)]  = '0;
    end

    // Reset state
    repeat (3) tick();
    chk_reset_vals("rst");
    #2 RST = 1'b0;
    tick();

    // Single write from hart 1
    pa_addr[1]  = 32'h8000_0010;
    pa_wdata[1] = 32'hDEAD_BEEF;
    pa_we[1]    = 1'b1;
    pa_ctrl[1]  = 3'b010;
    i_req       = 2'b10;
    rd          = $urandom;
    own         = rr_model(i_req, m_last);
    serve(own, 0, rd, 1'b1, 1);
    tick();
    chk("single_gnt_drop", 32'(o_gnt), 32'd0);
    chk("single_idle", 32'(o_idle), 32'd1);

    // Both harts request continuously: grants alternate 0,1,0,1
    rand_payload(0);
    rand_payload(1);
    i_req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      own = rr_model(i_req, m_last);
      rd  = $urandom;
      serve(own, $urandom_range(0, 3), rd, 1'b0, (n == 0) ? 1 : 2);
      rand_payload(own);
    end
    i_req = '0;
    tick();
    chk("simul_idle", 32'(o_idle), 32'd1);

    // Read under busy: busy high for 5 WAIT cycles
    rand_payload(1);
    pa_we[1] = 1'b0;
    i_req    = 2'b10;
    own      = rr_model(i_req, m_last);
    serve(own, 5, 32'h1234_5678, 1'b1, 1);
    repeat (3) tick();
    chk("rdata_hold", o_rdata, 32'h1234_5678);
    chk("busy_gnt_drop", 32'(o_gnt), 32'd0);

    // Lock: hart 0 runs three accesses back to back while hart 1 waits
    rand_payload(0);
    rand_payload(1);
    i_lock = 2'b01;
    i_req  = 2'b11;
    own    = rr_model(i_req, m_last);
    serve(own, $urandom_range(0, 3), $urandom, 1'b1, 1);
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("locked_gnt",  32'(o_gnt), 32'd1);
      chk("locked_idle", 32'(o_idle), 32'd0);
      rand_payload(0);
      i_req[0] = 1'b1;
      serve(0, $urandom_range(0, 3), $urandom, 1'b1, 1);
    end
    tick();
    tick();
    chk("locked_hold_gnt", 32'(o_gnt), 32'd1);
    i_lock = '0;
    serve(1, $urandom_range(0, 3), $urandom, 1'b1, 2);
    tick();

    // Lock watchdog: hart 0 sits locked with no request
    rand_payload(0);
    rand_payload(1);
    i_lock = 2'b01;
    i_req  = 2'b11;
    own    = rr_model(i_req, m_last);
    serve(own, 0, $urandom, 1'b1, 1);
    tick();
    chk("wd_locked_gnt", 32'(o_gnt), 32'd1);
    serve(1, $urandom_range(0, 2), $urandom, 1'b1, LM + 1);
    i_lock = '0;
    tick();

    // Random requests against the round-robin model
    pend = '0;
    for (int it = 0; it < 40; it++) begin
      if (it < 24) begin
        nb = NH'($urandom);
        if ((pend | nb) == '0) nb[hid_t'($urandom_range(0, NH - 1))] = 1'b1;
        for (int k = 0; k < NH; k++)
          if (nb[hid_t'(k)] && !pend[hid_t'(k)]) rand_payload(hid_t'(k));
        pend = pend | nb;
      end
      if (pend == '0) break;
      i_req = pend;
      own   = rr_model(pend, m_last);
      serve(own, $urandom_range(0, 4), $urandom, 1'b1, (it == 0) ? 1 : 2);
      pend[own] = 1'b0;
    end
    i_req = '0;
    tick();
    chk("rand_idle", 32'(o_idle), 32'd1);

    // Reset in the middle of WAIT
    rand_payload(0);
    i_req = 2'b01;
    own   = rr_model(i_req, m_last);
    serve(own, 1, $urandom, 1'b1, 1);
    tick();
    rand_payload(1);
    i_req = 2'b10;
    tick();
    chk("midrst_issue", 32'(o_mem_req), 32'd1);
    chk("midrst_gnt", 32'(o_gnt), 32'd2);
    i_mem_busy = 1'b1;
    tick();
    tick();
    chk("midrst_wait_idle", 32'(o_idle), 32'd0);
    #2 RST = 1'b1;
    #1;
    chk_reset_vals("midrst");
    #2 RST = 1'b0;
    i_mem_busy = 1'b0;
    m_last     = hid_t'(NH - 1);
    rand_payload(0);
    rand_payload(1);
    i_req = 2'b11;
    own   = rr_model(i_req, m_last);
    serve(own, 0, $urandom, 1'b1, 1);
    i_req = '0;
    tick();
    chk("final_idle", 32'(o_idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hart_mem_arbiter.md
# hart_mem_arbiter

Round-robin arbiter that shares the cluster's single memory/MMU access port between `N_HARTS` hart request ports in the RV cluster. Each access is run as an issue/wait/complete sequence. A hart may lock the port across back-to-back accesses, for example a page-table walk followed by the data access; a watchdog bounds how long a lock is held. The block sits between the per-hart cores and the shared DRAM/MMU path.

## Interface
Parameters:
- `N_HARTS`, 2, number of requesting harts (≥2)
- `LOCK_MAX`, 64, idle cycles a locked owner may hold the port before forced release
- `IDX_W`, `$clog2(N_HARTS)`, owner index width

Ports:
- `CLK` in 1: clock; all state on rising edge
- `RST` in 1: reset, asynchronous and active-high
- `i_req` in N_HARTS: per-hart access request, level; held with its payload until the matching `o_done`
- `i_addr` in 32·N_HARTS: per-hart address, hart k at `[32k+31:32k]`
- `i_wdata` in 32·N_HARTS: per-hart write data
- `i_we` in N_HARTS: per-hart write enable
- `i_ctrl` in 3·N_HARTS: per-hart access size/sign control
- `i_lock` in N_HARTS: keep grant after `o_done`
- `o_gnt` out N_HARTS: one-hot grant, or zero
- `o_done` out N_HARTS: one-cycle completion pulse to the owner
- `o_rdata` out 32: read data, valid while `o_done` is high and held afterwards
- `o_mem_req` out 1: one-cycle issue strobe to the shared port
- `o_mem_addr`, `o_mem_wdata` out 32: latched payload
- `o_mem_we` out 1: latched payload
- `o_mem_ctrl` out 3: latched payload
- `i_mem_busy` in 1: shared port busy
- `i_mem_rdata` in 32: shared port read data
- `o_owner` out IDX_W: current/last owner index
- `o_idle` out 1: FSM in IDLE

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE, LOCKED.
- **IDLE**
  - If `i_req` is nonzero, pick the winner by round-robin, searching from `last+1` modulo N_HARTS.
  - Latch the winner's payload, set `o_owner`, set `o_gnt`, then go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE**
  - `o_mem_req`=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - On the first cycle with `i_mem_busy`=0, capture `i_mem_rdata` into `o_rdata` and go to DONE.
  - Otherwise stay in WAIT with no timeout.
- **DONE**
  - `o_done[owner]`=1 for one cycle and `last` := owner.
  - If `i_lock[owner]`, go to LOCKED with the lock counter cleared; else go to IDLE and drop `o_gnt`.
- **LOCKED**
  - `o_gnt` stays asserted.
  - If `i_req[owner]`, latch the payload and go to ISSUE; this takes priority over lock release in the same cycle.
  - Else, if `!i_lock[owner]` or the counter reaches `LOCK_MAX-1`, go to IDLE.
  - Else increment the counter.

General rules:
- `o_mem_*` payload is stable from ISSUE through DONE.
- A requester deasserting `i_req` after grant does not abort the access; `o_done` still pulses.
- Other harts' requests are ignored until IDLE.

## Timing
- **Reset values:** all outputs 0 (`o_gnt`, `o_done`, `o_rdata`, `o_mem_*`, `o_owner`), `o_idle`=1, `last`=N_HARTS-1 so hart 0 wins first, state IDLE.
- **Asynchronous reset mid-access:** returns immediately to the reset values; the pending shared-port access is abandoned.
- **Unlocked access:** request seen in IDLE at cycle t → `o_mem_req` at t+1 → earliest `o_done` at t+3 (busy low at t+2). Minimum occupancy is 4 cycles per access.
- **Locked back-to-back access:** request seen in LOCKED at c → `o_mem_req` at c+1.
- **Simultaneous requests:** exactly one grant, rotating fairly.
- **Starvation bound:** a continuously requesting, unlocked hart waits at most N_HARTS-1 other accesses.

## Structure
- Shared package `hart_arb_pkg`:
  - state encoding constants (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_DONE`, `ARB_LOCKED`)
  - payload field widths (`ADDR_W`=32, `CTRL_W`=3)
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Parameters: `N_HARTS`.
  - Inputs: request vector, last index.
  - Outputs: winner index, valid.
- The FSM, payload registers and lock counter stay in `hart_mem_arbiter`.

## Test plan
- **Reset, then single access:** hart 1 requests a write to 0x8000_0010 / 0xDEAD_BEEF, `i_mem_busy` low immediately.
  - `o_mem_req` 1 cycle after the request.
  - `o_mem_addr`=0x8000_0010, `o_mem_we`=1.
  - `o_done[1]` at t+3; `o_gnt` returns to 0 the next cycle.
- **Simultaneous requests:** all harts request continuously after reset.
  - Grants go in order 0,1,0,1 (N_HARTS=2).
  - `o_done` never pulses for two harts at once.
- **Read under busy:** `i_mem_busy` held high for 5 cycles, then low with `i_mem_rdata`=0x1234_5678.
  - `o_done` arrives 1 cycle after busy falls.
  - `o_rdata`=0x1234_5678, held afterwards.
- **Lock:** hart 0 holds `i_lock` and issues 3 accesses while hart 1 requests.
  - Hart 1 is not granted until hart 0 drops `i_lock`.
  - Hart 1 is then granted on the next IDLE cycle.
- **Lock watchdog:** hart 0 locked, no `i_req` for `LOCK_MAX` cycles.
  - FSM forced back to IDLE after `LOCK_MAX` cycles in LOCKED.
  - The waiting hart 1 is granted.
- **Reset mid-WAIT:** `RST` asserted during busy.
  - All outputs reach their reset values asynchronously.
  - After release, hart 0 wins the first arbitration.
